param_sync_fifo: RTL
====================

# param_sync_fifo

Parametrised single-clock FIFO that succeeds the fixed 8x8 FIFO in the board top level. It generalises data width and depth and adds programmable almost-full/almost-empty levels, an occupancy count, sticky overflow/underflow error flags and a selectable first-word-fall-through read mode. It sits between the switch/input logic and the seven-segment display path, clocked from the divided system clock.

## Interface
- DATA_WIDTH, 8, width of data_in/data_out
- DEPTH, 16, number of entries; power of two, 4..1024
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AW (local), clog2(DEPTH), pointer width

- clock  in  1  single clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data, sampled when wr_en is accepted
- rd_en  in  1  read request (pop)
- data_out  out  DATA_WIDTH  read data
- data_valid  out  1  data_out holds valid read data
- full / empty  out  1  count == DEPTH / count == 0
- almost_full / almost_empty  out  1  level flags, per AF_LEVEL / AE_LEVEL
- count  out  AW+1  current occupancy, 0..DEPTH
- err_clr  in  1  clears overflow and underflow
- overflow / underflow  out  1  sticky error flags

## Operation
- Storage: DEPTH x DATA_WIDTH array; wr_ptr and rd_ptr are AW bits and wrap from DEPTH-1 to 0. count is a separate AW+1-bit register.
- Write accepted = wr_en & (!full | rd_accepted). Read accepted = rd_en & !empty.
- Count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Simultaneous wr_en and rd_en:
  - When full: both are accepted and count stays at DEPTH.
  - When empty: the write is accepted, the read is rejected, underflow is set and count goes to 1.
- Rejected write (wr_en & full & no accepted read): memory and pointers are unchanged and overflow is set.
- Rejected read (rd_en & empty): pointers are unchanged and underflow is set.
- overflow and underflow are sticky. They are cleared by reset or by err_clr. If err_clr and a new error occur in the same cycle, the flag stays set.
- FWFT=0 (standard mode):
  - An accepted read registers mem[rd_ptr] into data_out on the same edge, so it is visible the next cycle.
  - data_valid is high for exactly the cycle after each accepted read.
  - data_out holds its last value otherwise.
- FWFT=1:
  - data_out = mem[rd_ptr] (combinational read) and data_valid = !empty.
  - rd_en acknowledges the current word; the next word appears the cycle after.
- Flags are decoded combinationally from the count register, so they change only on clock edges.

## Timing
- Reset (synchronous) sets wr_ptr=0, rd_ptr=0, count=0, data_out=0, data_valid=0, overflow=0, underflow=0.
- Outputs right after reset: empty=1, full=0, almost_empty=1 (AE_LEVEL>=0), almost_full=0.
- Memory contents are not reset.
- Reset asserted mid-operation discards all contents at that edge and takes priority over wr_en, rd_en and err_clr in the same cycle.
- Write latency: data written at edge N is readable at edge N+1.
  - FWFT=1: data_out shows that word in cycle N+1.
  - FWFT=0: a read at edge N+1 presents the word in cycle N+2.
- Flag update: count, full, empty, almost_* and the error flags update on the same edge as the accepted (or rejected) operation.
- Back-to-back reads: one word per cycle. No bubbles are required in either mode.

## Test plan
- Reset, then idle 3 cycles -> count=0, empty=1, almost_empty=1, full=0, data_valid=0, overflow=0, underflow=0.
- DEPTH=16: write 0x01..0x10 on consecutive cycles, then read 16 consecutive cycles (FWFT=0) -> data_out 0x01..0x10 in order, each on the cycle after its read. almost_full is set at count=14, full at 16, and empty returns after the last read.
- Fill to full, assert wr_en with 0xAA alone -> overflow=1, count stays 16, 0xAA never appears on reads. Pulse err_clr -> overflow=0.
- Full, with wr_en=rd_en=1 and data 0x55 -> count stays 16, the oldest word is popped, and 0x55 is read last after draining. Then, with the FIFO empty, wr_en=rd_en=1 -> count=1 and underflow=1.
- Wrap-around: 40 cycles of interleaved write/read with count held at 3 -> pointers wrap at least twice and the read data sequence exactly matches the write sequence.
- FWFT=1: write 0x3C -> in the next cycle data_out=0x3C and data_valid=1 without rd_en. A single rd_en then gives empty=1 and data_valid=0. Reset asserted during a write burst at count=5 -> count=0 and empty=1 on the next cycle.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with level flags, occupancy count, sticky
// overflow/underflow flags and a selectable first-word-fall-through read port.
module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      rd_en,
    input  logic                      err_clr,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      data_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_L     = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_L     = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [AW:0]           count_r;
    logic [AW:0]           count_nxt_s;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  rd_acc_s;
    logic                  wr_acc_s;
    logic                  wr_rej_s;
    logic                  rd_rej_s;

    assign full_s   = (count_r == DEPTH_L);
    assign empty_s  = (count_r == CNT_ZERO);
    // A pop frees a slot in the same edge, so a full FIFO still takes a write alongside a read.
    assign rd_acc_s = rd_en & ~empty_s;
    assign wr_acc_s = wr_en & (~full_s | rd_acc_s);
    assign wr_rej_s = wr_en & ~wr_acc_s;
    assign rd_rej_s = rd_en & empty_s;

    // Next occupancy from the accepted write/read pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (wr_acc_s && !reset) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= CNT_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_nxt_s;
            overflow_r  <= (overflow_r & ~err_clr) | wr_rej_s;
            underflow_r <= (underflow_r & ~err_clr) | rd_rej_s;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign data_out   = mem_r[rd_ptr_r];
            assign data_valid = ~empty_s;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_r;
            logic                  dvalid_r;

            // Registered read port: word popped at this edge is presented next cycle.
            always_ff @(posedge clock) begin
                if (reset) begin
                    dout_r   <= {DATA_WIDTH{1'b0}};
                    dvalid_r <= 1'b0;
                end else begin
                    dvalid_r <= rd_acc_s;
                    if (rd_acc_s) begin
                        dout_r <= mem_r[rd_ptr_r];
                    end
                end
            end

            assign data_out   = dout_r;
            assign data_valid = dvalid_r;
        end
    endgenerate

    assign count        = count_r;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_r >= AF_L);
    assign almost_empty = (count_r <= AE_L);
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule
